// File: rtl/ring_controller_stage3_wbq.sv
// Ring controller stage 3: applies fill responses addressed to this node,
// wakes waiting threads, queues writebacks and drives the registered ring output.

package ring_controller_stage3_wbq_pkg;

    localparam int CACHE_LINE_BITS  = 64;
    localparam int CACHE_LINE_BYTES = CACHE_LINE_BITS / 8;
    localparam int THREADS_PER_CORE = 4;
    localparam int THREAD_IDX_BITS  = $clog2(THREADS_PER_CORE);
    localparam int L1D_WAYS         = 4;
    localparam int L1D_SETS         = 16;
    localparam int NODE_BITS        = 2;
    localparam int CACHE_TYPE_BITS  = 2;
    localparam int SET_LSB          = $clog2(CACHE_LINE_BYTES);
    localparam int SET_BITS         = $clog2(L1D_SETS);

    typedef logic [31:0]                    scalar_t;
    typedef logic [$clog2(L1D_WAYS)-1:0]    l1d_way_idx_t;
    typedef logic [SET_BITS-1:0]            l1d_set_idx_t;
    typedef logic [CACHE_LINE_BITS-1:0]     cache_line_data_t;

    typedef enum logic [1:0] {
        PKT_READ_SHARED      = 2'd0,
        PKT_WRITE_INVALIDATE = 2'd1,
        PKT_FLUSH            = 2'd2,
        PKT_L2_WRITEBACK     = 2'd3
    } ring_packet_type_t;

    typedef struct packed {
        logic                       valid;
        logic                       ack;
        logic [NODE_BITS-1:0]       dest_node;
        ring_packet_type_t          packet_type;
        logic [CACHE_TYPE_BITS-1:0] cache_type;
        scalar_t                    address;
        cache_line_data_t           data;
    } ring_packet_t;

endpackage

module ring_controller_stage3_wbq
    import ring_controller_stage3_wbq_pkg::*;
#(
    parameter int NODE_ID       = 0,
    parameter int NUM_L1        = 2,
    parameter int WB_FIFO_DEPTH = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  ring_packet_t                                rc2_packet,
    input  logic                                        rc2_need_writeback,
    input  scalar_t                                     rc2_evicted_line_addr,
    input  l1d_way_idx_t                                rc2_fill_way_idx,
    input  logic [NUM_L1-1:0][THREAD_IDX_BITS-1:0]      rc2_miss_entry,
    input  cache_line_data_t                            dd_ddata_read_data,
    output logic [NUM_L1-1:0]                           rc_update_en,
    output l1d_way_idx_t                                rc_update_way,
    output l1d_set_idx_t                                rc_update_set,
    output cache_line_data_t                            rc_update_data,
    output logic [NUM_L1-1:0]                           rc3_wake,
    output logic [NUM_L1-1:0][THREAD_IDX_BITS-1:0]      rc3_wake_entry,
    output logic                                        rc3_wb_stall,
    output logic                                        rc3_wb_overflow,
    output ring_packet_t                                packet_out
);

    localparam int PTR_W = $clog2(WB_FIFO_DEPTH);
    localparam int CNT_W = $clog2(WB_FIFO_DEPTH + 1);

    // Queue storage: address and line data of each pending writeback
    scalar_t          wbAddr_q [WB_FIFO_DEPTH];
    cache_line_data_t wbData_q [WB_FIFO_DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] fifoCount_q, fifoCount_d;
    logic             overflow_q, overflow_d;
    ring_packet_t     packetOut_q, packetOut_d;

    logic ackForMe;
    logic slotFree;
    logic fifoEmpty;
    logic fifoFull;
    logic doDeq;
    logic doBypass;
    logic wantEnq;
    logic overflowEvent;
    logic doEnq;

    // Pointers wrap at the queue depth, which need not be a power of two
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (32'(p) == WB_FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // Builds a writeback packet in the form used by both bypass and queued injection
    function automatic ring_packet_t makeWb(input scalar_t addr, input cache_line_data_t data);
        ring_packet_t p;
        p             = '0;
        p.valid       = 1'b1;
        p.packet_type = PKT_L2_WRITEBACK;
        p.address     = addr;
        p.data        = data;
        return p;
    endfunction

    // Decide whether the incoming response is ours and how the outgoing slot is used
    always_comb begin
        ackForMe      = rc2_packet.valid && rc2_packet.ack
                        && (32'(rc2_packet.dest_node) == NODE_ID)
                        && (32'(rc2_packet.cache_type) < NUM_L1);
        slotFree      = !rc2_packet.valid || ackForMe;
        fifoEmpty     = (fifoCount_q == '0);
        fifoFull      = (fifoCount_q == CNT_W'(WB_FIFO_DEPTH));
        doDeq         = slotFree && !fifoEmpty;
        doBypass      = slotFree && fifoEmpty && rc2_need_writeback;
        wantEnq       = rc2_need_writeback && !doBypass;
        overflowEvent = wantEnq && fifoFull && !doDeq;
        doEnq         = wantEnq && !overflowEvent;
    end

    // Fill and wake outputs follow stage 2 with no register in between
    always_comb begin
        rc_update_en = '0;
        for (int c = 0; c < NUM_L1; c++) begin
            rc_update_en[c] = ackForMe && (32'(rc2_packet.cache_type) == c);
        end
        rc3_wake       = rc_update_en;
        rc3_wake_entry = rc2_miss_entry;
        rc_update_way  = rc2_fill_way_idx;
        rc_update_set  = rc2_packet.address[SET_LSB +: SET_BITS];
        rc_update_data = rc2_packet.data;
    end

    // Next ring slot contents plus queue pointer, count and error-flag updates
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        fifoCount_d = fifoCount_q;
        overflow_d  = overflow_q || overflowEvent;
        packetOut_d = '0;

        if (rc2_packet.valid && !ackForMe) begin
            packetOut_d = rc2_packet;
        end else if (doDeq) begin
            packetOut_d = makeWb(wbAddr_q[head_q], wbData_q[head_q]);
        end else if (doBypass) begin
            packetOut_d = makeWb(rc2_evicted_line_addr, dd_ddata_read_data);
        end

        if (doDeq) begin
            head_d = nextPtr(head_q);
        end
        if (doEnq) begin
            tail_d = nextPtr(tail_q);
        end

        case ({doEnq, doDeq})
            2'b10:   fifoCount_d = fifoCount_q + CNT_W'(1);
            2'b01:   fifoCount_d = fifoCount_q - CNT_W'(1);
            default: fifoCount_d = fifoCount_q;
        endcase
    end

    // Control state register; reset discards the queue by clearing pointers and count
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            fifoCount_q <= '0;
            overflow_q  <= 1'b0;
            packetOut_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            fifoCount_q <= fifoCount_d;
            overflow_q  <= overflow_d;
            packetOut_q <= packetOut_d;
        end
    end

    // Queue payload write at the tail; stale entries are harmless once pointers reset
    always_ff @(posedge clk) begin
        if (doEnq && !reset) begin
            wbAddr_q[tail_q] <= rc2_evicted_line_addr;
            wbData_q[tail_q] <= dd_ddata_read_data;
        end
    end

    assign rc3_wb_stall    = (fifoCount_q >= CNT_W'(WB_FIFO_DEPTH - 2));
    assign rc3_wb_overflow = overflow_q;
    assign packet_out      = packetOut_q;

    // A writeback arriving at a full queue with no free slot is lost
    wbQueueNoOverflow: assert property (@(posedge clk) disable iff (reset) !overflowEvent)
        else $warning("writeback queue full, entry dropped");

endmodule

// File: tb/tb_ring_controller_stage3_wbq.sv
// Testbench for ring_controller_stage3_wbq: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.

module tb_ring_controller_stage3_wbq;
    import ring_controller_stage3_wbq_pkg::*;

    localparam int NODE_ID = 0;
    localparam int NUM_L1  = 2;
    localparam int DEPTH   = 4;

    typedef struct packed {
        scalar_t          addr;
        cache_line_data_t data;
    } wbEntry_t;

    logic                                   clk;
    logic                                   reset;
    ring_packet_t                           rc2Packet;
    logic                                   needWb;
    scalar_t                                evAddr;
    l1d_way_idx_t                           fillWay;
    logic [NUM_L1-1:0][THREAD_IDX_BITS-1:0] missEntry;
    cache_line_data_t                       readData;
    logic [NUM_L1-1:0]                      updateEn;
    l1d_way_idx_t                           updateWay;
    l1d_set_idx_t                           updateSet;
    cache_line_data_t                       updateData;
    logic [NUM_L1-1:0]                      wake;
    logic [NUM_L1-1:0][THREAD_IDX_BITS-1:0] wakeEntry;
    logic                                   wbStall;
    logic                                   wbOverflow;
    ring_packet_t                           packetOut;

    int compared   = 0;
    int mismatched = 0;

    wbEntry_t modelQ[$];
    logic     modelOverflow;

    logic [NUM_L1-1:0] lastEn;
    ring_packet_t      lastOut;
    logic              lastStall;
    logic              lastOverflow;

    ring_controller_stage3_wbq #(
        .NODE_ID       (NODE_ID),
        .NUM_L1        (NUM_L1),
        .WB_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .rc2_packet            (rc2Packet),
        .rc2_need_writeback    (needWb),
        .rc2_evicted_line_addr (evAddr),
        .rc2_fill_way_idx      (fillWay),
        .rc2_miss_entry        (missEntry),
        .dd_ddata_read_data    (readData),
        .rc_update_en          (updateEn),
        .rc_update_way         (updateWay),
        .rc_update_set         (updateSet),
        .rc_update_data        (updateData),
        .rc3_wake              (wake),
        .rc3_wake_entry        (wakeEntry),
        .rc3_wb_stall          (wbStall),
        .rc3_wb_overflow       (wbOverflow),
        .packet_out            (packetOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic cache_line_data_t randLine();
        return {$urandom, $urandom};
    endfunction

    function automatic ring_packet_t mkPkt(input logic v, input logic a, input int dest,
                                           input int ct, input scalar_t addr, input int ptype);
        ring_packet_t p;
        p             = '0;
        p.valid       = v;
        p.ack         = a;
        p.dest_node   = NODE_BITS'(dest);
        p.cache_type  = CACHE_TYPE_BITS'(ct);
        p.packet_type = ring_packet_type_t'(ptype);
        p.address     = addr;
        p.data        = randLine();
        return p;
    endfunction

    function automatic ring_packet_t wbPkt(input scalar_t addr, input cache_line_data_t data);
        ring_packet_t p;
        p             = '0;
        p.valid       = 1'b1;
        p.packet_type = PKT_L2_WRITEBACK;
        p.address     = addr;
        p.data        = data;
        return p;
    endfunction

    // One clock of traffic: drive, check fill/wake, predict the ring slot and queue, check registered outputs
    task automatic applyStimulus(input ring_packet_t pkt, input logic wb, input scalar_t addr,
                                 input cache_line_data_t data);
        logic              forMe;
        logic [NUM_L1-1:0] expEn;
        ring_packet_t      expOut;
        int                sizeBefore;
        logic              popped;
        logic              bypassed;
        @(negedge clk);
        rc2Packet = pkt;
        needWb    = wb;
        evAddr    = addr;
        readData  = data;
        fillWay   = l1d_way_idx_t'($urandom);
        missEntry = (NUM_L1 * THREAD_IDX_BITS)'($urandom);
        #1;
        forMe = pkt.valid && pkt.ack && (int'(pkt.dest_node) == NODE_ID) && (int'(pkt.cache_type) < NUM_L1);
        expEn = '0;
        if (forMe) expEn[pkt.cache_type] = 1'b1;
        lastEn = updateEn;
        checkOutput("update_en", 128'(updateEn), 128'(expEn));
        checkOutput("wake", 128'(wake), 128'(expEn));
        checkOutput("wake_entry", 128'(wakeEntry), 128'(missEntry));
        checkOutput("update_way", 128'(updateWay), 128'(fillWay));
        checkOutput("update_set", 128'(updateSet), 128'((pkt.address / CACHE_LINE_BYTES) % L1D_SETS));
        checkOutput("update_data", 128'(updateData), 128'(pkt.data));

        sizeBefore = modelQ.size();
        popped     = 1'b0;
        bypassed   = 1'b0;
        if (pkt.valid && !forMe) begin
            expOut = pkt;
        end else if (sizeBefore > 0) begin
            wbEntry_t e;
            e      = modelQ.pop_front();
            expOut = wbPkt(e.addr, e.data);
            popped = 1'b1;
        end else if (wb) begin
            expOut   = wbPkt(addr, data);
            bypassed = 1'b1;
        end else begin
            expOut = '0;
        end
        if (wb && !bypassed) begin
            if (sizeBefore == DEPTH && !popped) modelOverflow = 1'b1;
            else modelQ.push_back('{addr: addr, data: data});
        end

        @(posedge clk);
        #1;
        lastOut      = packetOut;
        lastStall    = wbStall;
        lastOverflow = wbOverflow;
        checkOutput("packet_out", 128'(packetOut), 128'(expOut));
        checkOutput("wb_stall", 128'(wbStall), 128'(modelQ.size() >= DEPTH - 2));
        checkOutput("wb_overflow", 128'(wbOverflow), 128'(modelOverflow));
    endtask

    // Reset cycle with arbitrary traffic present, which reset must override
    task automatic doReset();
        @(negedge clk);
        reset     = 1'b1;
        rc2Packet = mkPkt(1'b1, 1'b1, NODE_ID, 0, $urandom, 0);
        needWb    = 1'b1;
        evAddr    = $urandom;
        readData  = randLine();
        @(posedge clk);
        #1;
        checkOutput("reset_packet_out", 128'(packetOut), 128'(0));
        checkOutput("reset_stall", 128'(wbStall), 128'(0));
        checkOutput("reset_overflow", 128'(wbOverflow), 128'(0));
        modelQ.delete();
        modelOverflow = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idleSlot();
        applyStimulus('0, 1'b0, '0, '0);
    endtask

    initial begin
        cache_line_data_t d;
        ring_packet_t     p;
        reset         = 1'b1;
        rc2Packet     = '0;
        needWb        = 1'b0;
        evAddr        = '0;
        fillWay       = '0;
        missEntry     = '0;
        readData      = '0;
        modelOverflow = 1'b0;
        doReset();

        // I$ fill response for this node, no writeback
        applyStimulus(mkPkt(1'b1, 1'b1, NODE_ID, 1, 32'h0000_0148, 0), 1'b0, '0, '0);
        checkOutput("icache_fill_en", 128'(lastEn), 128'(2'b10));
        checkOutput("icache_fill_out", 128'(lastOut), 128'(0));

        // D$ fill with eviction, empty queue: bypass
        d = randLine();
        applyStimulus(mkPkt(1'b1, 1'b1, NODE_ID, 0, 32'h0000_2040, 0), 1'b1, 32'h1000, d);
        checkOutput("bypass_out", 128'(lastOut), 128'(wbPkt(32'h1000, d)));
        checkOutput("bypass_stall", 128'(lastStall), 128'(0));

        // Flushes on occupied slots, then drain on empty slots in order
        applyStimulus(mkPkt(1'b1, 1'b0, 1, 0, 32'h3000, 1), 1'b1, 32'hA0, randLine());
        applyStimulus(mkPkt(1'b1, 1'b0, 2, 1, 32'h3040, 1), 1'b1, 32'hB0, randLine());
        checkOutput("stall_at_two", 128'(lastStall), 128'(1));
        applyStimulus(mkPkt(1'b1, 1'b0, 3, 0, 32'h3080, 2), 1'b1, 32'hC0, randLine());
        idleSlot();
        checkOutput("drain_first", 128'(lastOut.address), 128'(32'hA0));
        idleSlot();
        checkOutput("drain_second", 128'(lastOut.address), 128'(32'hB0));
        idleSlot();
        checkOutput("drain_third", 128'(lastOut.address), 128'(32'hC0));
        checkOutput("drained_stall", 128'(lastStall), 128'(0));

        // Full queue: free slot swaps head for new entry, occupied slot overflows
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(mkPkt(1'b1, 1'b0, 1, 0, $urandom, 0), 1'b1, 32'h100 + 32'(i * 16), randLine());
        end
        applyStimulus(mkPkt(1'b1, 1'b1, NODE_ID, 0, 32'h40, 0), 1'b1, 32'h200, randLine());
        checkOutput("full_swap_head", 128'(lastOut.address), 128'(32'h100));
        checkOutput("full_swap_no_ovf", 128'(lastOverflow), 128'(0));
        applyStimulus(mkPkt(1'b1, 1'b0, 1, 0, $urandom, 0), 1'b1, 32'h300, randLine());
        checkOutput("overflow_set", 128'(lastOverflow), 128'(1));
        applyStimulus(mkPkt(1'b1, 1'b0, 2, 0, $urandom, 0), 1'b0, '0, '0);
        checkOutput("overflow_sticky", 128'(lastOverflow), 128'(1));
        for (int i = 0; i < DEPTH; i++) idleSlot();
        checkOutput("after_drain_last", 128'(lastOut.address), 128'(32'h200));

        // Acked packets not consumed here are forwarded
        p = mkPkt(1'b1, 1'b1, 1, 0, 32'h5000, 0);
        applyStimulus(p, 1'b0, '0, '0);
        checkOutput("other_node_en", 128'(lastEn), 128'(0));
        checkOutput("other_node_fwd", 128'(lastOut), 128'(p));
        p = mkPkt(1'b1, 1'b1, NODE_ID, 2, 32'h5040, 0);
        applyStimulus(p, 1'b0, '0, '0);
        checkOutput("bad_cache_en", 128'(lastEn), 128'(0));
        checkOutput("bad_cache_fwd", 128'(lastOut), 128'(p));

        // Reset with entries queued discards them
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mkPkt(1'b1, 1'b0, 3, 0, $urandom, 0), 1'b1, 32'h700 + 32'(i), randLine());
        end
        doReset();
        idleSlot();
        checkOutput("post_reset_idle", 128'(lastOut.valid), 128'(0));

        // Randomized traffic, mostly honouring the stall
        for (int i = 0; i < 1500; i++) begin
            logic wbReq;
            if (i == 750) doReset();
            p = mkPkt(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom, $urandom_range(0, 3));
            wbReq = (modelQ.size() >= DEPTH - 2) ? ($urandom_range(0, 9) == 0) : 1'($urandom);
            applyStimulus(p, wbReq, $urandom, randLine());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
